sram_1rw_arbiter: RTL
=====================

# sram_1rw_arbiter

Two-requester controller for a single-port (1RW) FreePDK45 OpenRAM macro, such as a tag array, a way data array or the L2 TLB RAM. It arbitrates read and write requests round-robin, drives the macro's active-high enable and write-mode pins, and returns read data through per-port response registers with valid/ready backpressure. An optional post-reset scrub zeroes every entry before requests are accepted.

## Interface
- DEPTH, 64, number of macro entries.
- ADDR_W, 6, address width; ceil(log2(DEPTH)).
- DATA_W, 176, data width.
- MASK_W, 8, write-mask width; DATA_W divisible by MASK_W.
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- init_done  out  1  macro ready for requests.
- {a,b}_req_valid  in  1  request present.
- {a,b}_req_ready  out  1  request accepted this cycle when high with valid.
- {a,b}_req_write  in  1  1 = write, 0 = read.
- {a,b}_req_addr  in  ADDR_W  entry index.
- {a,b}_req_wdata  in  DATA_W  write data.
- {a,b}_req_wmask  in  MASK_W  per-slice write enable (slice = DATA_W/MASK_W bits).
- {a,b}_resp_valid  out  1  read data available.
- {a,b}_resp_ready  in  1  consumer takes data.
- {a,b}_resp_rdata  out  DATA_W  read data.
- mem_en  out  1  macro enable (wrapper inverts to csb0).
- mem_wmode  out  1  macro write (wrapper inverts to web0).
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_wmask  out  MASK_W.
- mem_rdata  in  DATA_W  macro dout, valid one cycle after a read enable.

## Operation
- State machine: SCRUB -> RUN. SCRUB is entered on reset only when scrub is compiled in. Otherwise the block enters RUN on the first clock edge after reset deassertion.
- Eligibility:
  - Writes are always eligible in RUN.
  - A read from port X is eligible only when no response is held for X (resp_valid low), or the held response is leaving this cycle (resp_valid & resp_ready).
- Arbitration:
  - One grant per cycle, among eligible valid requests.
  - Round-robin pointer: the last-granted port gets lowest priority. The pointer points to A at reset and changes only on a grant.
  - req_ready is combinational: RUN & eligible & granted. A ready never depends on its own valid being asserted.
- Macro drive on grant: mem_en=1, mem_wmode=req_write, mem_addr/wdata/wmask from the granted port.
  - mem_wdata/wmask are don't-care on reads but driven from the port.
  - With no grant, mem_en=0 and the other mem_* outputs hold their last values.
- Read return:
  - A read accepted in cycle N gives X_resp_valid=1 in N+1, with X_resp_rdata = mem_rdata.
  - If resp_ready is low in N+1, mem_rdata is captured into the X hold register. From N+2 onward rdata comes from the hold register and valid stays high until resp_ready.
  - The macro may be accessed again in N+1 without corrupting X's held data.
- A write issued to the same address as a read in flight does not affect that read's returned data (macro read-before-write is not relied on; the accesses are in different cycles).
- Simultaneous events:
  - A and B both valid with a tie: the pointer decides.
  - A response dequeue and a new read accept in the same cycle on the same port: both allowed. The new data appears in the next cycle.

## Timing
- Reset values: init_done=0, all req_ready=0, resp_valid=0, resp_rdata=0, mem_en=0, mem_wmode=0, mem_addr=0, mem_wdata=0, mem_wmask=0. Round-robin pointer = A.
- Read latency: accept (N) to resp_valid (N+1), exactly 1 cycle when the slot is free.
- Write: takes effect at the accept edge; produces no response.
- Throughput: 1 access per cycle total.
- Reset asserted mid-operation:
  - All outputs return to reset values asynchronously.
  - Held responses and in-flight reads are discarded.
  - The scrub restarts from address 0.

## Configuration
- SRAM_ARB_SCRUB_EN defined:
  - After reset, SCRUB writes zero to addresses 0..DEPTH-1 in consecutive cycles: mem_en=1, mem_wmode=1, mask all ones.
  - req_ready stays 0 throughout SCRUB.
  - init_done rises on the edge after the last write, i.e. DEPTH cycles after the first post-reset edge, and RUN begins.
- SRAM_ARB_SCRUB_EN undefined:
  - No scrub logic or counter is present.
  - init_done=1 and RUN begin on the first edge after reset release. Macro contents are undefined.

## Test plan
- Reset, scrub on (DEPTH=64) -> mem_en/wmode high for exactly 64 cycles with addresses 0..63, wdata=0, wmask=0xFF; init_done=1 on cycle 65; then read addr 17 -> rdata 0 on the next cycle.
- A writes 0xA5… to addr 5, mask 0x0F; then B reads addr 5 -> upper four slices 0, lower four slices 0xA5…, with B_resp_valid exactly one cycle after acceptance.
- A and B both issue continuous reads with resp_ready=1 -> grants alternate A,B,A,B; no idle macro cycles.
- A read accepted with A_resp_ready=0 for 5 cycles while B performs 5 accesses -> A_resp_rdata stays at the original value; A_req_ready=0 for A reads until the dequeue cycle; dequeue and new accept occur in the same cycle.
- Reset asserted during scrub at address 30, and separately while A holds a response -> all outputs cleared immediately; scrub restarts at 0; A_resp_valid=0.
- Scrub off -> init_done=1 one edge after reset release; a back-to-back write then read of the same addr returns the written data.

Source files
------------

// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: round-robin two-port front end for a single-port (1RW) SRAM macro.
// Define SRAM_ARB_SCRUB_EN to zero every entry after reset before requests are accepted.
module sram_1rw_arbiter #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 176,
  parameter int unsigned MASK_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,

  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_write,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  input  logic [MASK_W-1:0] a_req_wmask,
  output logic              a_resp_valid,
  input  logic              a_resp_ready,
  output logic [DATA_W-1:0] a_resp_rdata,

  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_write,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  input  logic [MASK_W-1:0] b_req_wmask,
  output logic              b_resp_valid,
  input  logic              b_resp_ready,
  output logic [DATA_W-1:0] b_resp_rdata,

  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (DATA_W % MASK_W != 0 || DEPTH > (2 ** ADDR_W)) begin : g_bad_cfg
    $error("sram_1rw_arbiter: inconsistent DEPTH/ADDR_W/DATA_W/MASK_W");
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
`ifdef SRAM_ARB_SCRUB_EN
  typedef enum logic [1:0] {StInit, StScrub, StRun} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;

  always_comb begin
    state_d      = state_q;
    scrub_addr_d = scrub_addr_q;
    case (state_q)
      StInit:  state_d = StScrub;
      StScrub: begin
        scrub_addr_d = scrub_addr_q + 1'b1;
        if (scrub_addr_q == ADDR_W'(DEPTH - 1)) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StInit;
      scrub_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
    end
  end
`else
  typedef enum logic {StInit, StRun} state_e;
  state_e state_q, state_d;

  always_comb begin
    state_d = StRun;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StInit;
    else       state_q <= state_d;
  end
`endif

  logic run;
  assign run       = (state_q == StRun);
  assign init_done = run;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic prio_b_q;  // set once A has been granted, so B wins the next tie
  logic a_elig, b_elig, a_acc, b_acc;

  // A read may only go out when its response slot is free or draining now.
  assign a_elig = run & (a_req_write | ~a_resp_valid | a_resp_ready);
  assign b_elig = run & (b_req_write | ~b_resp_valid | b_resp_ready);

  assign a_req_ready = a_elig & (~(b_req_valid & b_elig) | ~prio_b_q);
  assign b_req_ready = b_elig & (~(a_req_valid & a_elig) |  prio_b_q);

  assign a_acc = a_req_valid & a_req_ready;
  assign b_acc = b_req_valid & b_req_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      prio_b_q <= 1'b0;
    else if (a_acc) prio_b_q <= 1'b1;
    else if (b_acc) prio_b_q <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Macro drive; address/data/mode hold their last value when idle
  // ---------------------------------------------------------------------------
  logic              wmode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = wmode_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wmask = wmask_q;
`ifdef SRAM_ARB_SCRUB_EN
    if (state_q == StScrub) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = scrub_addr_q;
      mem_wdata = '0;
      mem_wmask = '1;
    end else
`endif
    if (a_acc) begin
      mem_en    = 1'b1;
      mem_wmode = a_req_write;
      mem_addr  = a_req_addr;
      mem_wdata = a_req_wdata;
      mem_wmask = a_req_wmask;
    end else if (b_acc) begin
      mem_en    = 1'b1;
      mem_wmode = b_req_write;
      mem_addr  = b_req_addr;
      mem_wdata = b_req_wdata;
      mem_wmask = b_req_wmask;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wmode_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      wmode_q <= mem_wmode;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wmask_q <= mem_wmask;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: data comes straight off the macro the cycle after the read,
  // and is parked in a hold register if the consumer stalls.
  // ---------------------------------------------------------------------------
  logic              a_inflight_q, a_held_q, b_inflight_q, b_held_q;
  logic [DATA_W-1:0] a_hold_q, b_hold_q;

  assign a_resp_valid = a_inflight_q | a_held_q;
  assign a_resp_rdata = a_inflight_q ? mem_rdata : a_hold_q;
  assign b_resp_valid = b_inflight_q | b_held_q;
  assign b_resp_rdata = b_inflight_q ? mem_rdata : b_hold_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_inflight_q <= 1'b0;
      a_held_q     <= 1'b0;
      a_hold_q     <= '0;
    end else begin
      a_inflight_q <= a_acc & ~a_req_write;
      if (a_inflight_q & ~a_resp_ready) begin
        a_held_q <= 1'b1;
        a_hold_q <= mem_rdata;
      end else if (a_resp_ready) begin
        a_held_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_inflight_q <= 1'b0;
      b_held_q     <= 1'b0;
      b_hold_q     <= '0;
    end else begin
      b_inflight_q <= b_acc & ~b_req_write;
      if (b_inflight_q & ~b_resp_ready) begin
        b_held_q <= 1'b1;
        b_hold_q <= mem_rdata;
      end else if (b_resp_ready) begin
        b_held_q <= 1'b0;
      end
    end
  end

endmodule
